// File: rtl/handshake_bus_sync.sv
// Toggle req/ack handshake that carries one WIDTH-bit word from clk_wr to clk_rd.
// Define HANDSHAKE_BUS_SYNC_SKID_EN to add a one-deep write-side skid register.
module handshake_bus_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_wr,
  input  logic             rst_wr,
  input  logic             clk_rd,
  input  logic             rst_rd,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } wr_state_t;

  wr_state_t              state;
  logic [WIDTH-1:0]       hold_r;
  logic                   req_tgl;
  logic                   ack_tgl;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_prev;
  logic                   ack_edge;
  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_prev;
  logic                   req_edge;
  logic                   wr_accept;

  assign wr_accept = wr_valid && wr_ready;
  assign ack_edge  = ack_sync[SYNC_STAGES-1] ^ ack_prev;
  assign req_edge  = req_sync[SYNC_STAGES-1] ^ req_prev;

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      ack_sync <= '0;
      ack_prev <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_tgl};
      ack_prev <= ack_sync[SYNC_STAGES-1];
    end
  end

`ifdef HANDSHAKE_BUS_SYNC_SKID_EN
  logic [WIDTH-1:0] skid_r;
  logic             skid_full;

  // wr_ready tracks ~skid_full; an ack with a parked word relaunches it without leaving WAIT_ACK.
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      state     <= IDLE;
      hold_r    <= '0;
      req_tgl   <= 1'b0;
      skid_r    <= '0;
      skid_full <= 1'b0;
      wr_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_accept) begin
            hold_r  <= wr_data;
            req_tgl <= ~req_tgl;
            state   <= WAIT_ACK;
            busy    <= 1'b1;
          end
        end
        WAIT_ACK: begin
          if (ack_edge) begin
            if (skid_full) begin
              hold_r    <= skid_r;
              skid_full <= 1'b0;
              req_tgl   <= ~req_tgl;
              wr_ready  <= 1'b1;
            end else if (wr_accept) begin
              hold_r  <= wr_data;
              req_tgl <= ~req_tgl;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (wr_accept) begin
            skid_r    <= wr_data;
            skid_full <= 1'b1;
            wr_ready  <= 1'b0;
          end
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      state    <= IDLE;
      hold_r   <= '0;
      req_tgl  <= 1'b0;
      wr_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_accept) begin
            hold_r   <= wr_data;
            req_tgl  <= ~req_tgl;
            state    <= WAIT_ACK;
            wr_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        WAIT_ACK: begin
          if (ack_edge) begin
            state    <= IDLE;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
      endcase
    end
  end
`endif

  // hold_r is only sampled here after req_tgl has settled through the chain, so it is stable.
  always_ff @(posedge clk_rd or posedge rst_rd) begin
    if (rst_rd) begin
      req_sync <= '0;
      req_prev <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ack_tgl  <= 1'b0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], req_tgl};
      req_prev <= req_sync[SYNC_STAGES-1];
      if (req_edge) begin
        rd_data  <= hold_r;
        rd_valid <= 1'b1;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
        ack_tgl  <= ~ack_tgl;
      end
    end
  end

endmodule

// File: tb/tb_handshake_bus_sync.sv
// Scoreboard bench for handshake_bus_sync: issued words are queued, a read-side monitor pops and compares.
`timescale 1ns/1ps
module tb_handshake_bus_sync;

  localparam int WIDTH = 32;

  logic             clk_wr = 1'b0;
  logic             clk_rd = 1'b0;
  logic             rst_wr;
  logic             rst_rd;
  logic [WIDTH-1:0] wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic             busy;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;

  realtime          wr_half = 5.0;
  realtime          rd_half = 13.5;
  int               checks = 0;
  int               errors = 0;
  int               delivered = 0;
  int               rd_valid_cycles = 0;
  logic             rd_random = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  handshake_bus_sync #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk_wr  (clk_wr),
    .rst_wr  (rst_wr),
    .clk_rd  (clk_rd),
    .rst_rd  (rst_rd),
    .wr_data (wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .busy    (busy),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready)
  );

  initial forever #(wr_half) clk_wr = ~clk_wr;
  initial forever #(rd_half) clk_rd = ~clk_rd;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Every read-side handshake must match the oldest outstanding issued word.
  always @(negedge clk_rd) begin
    if (rd_valid === 1'b1) rd_valid_cycles++;
    if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
      delivered++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got 0x%08h, required no delivery", rd_data);
      end else begin
        checkOutput("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk_rd) begin
    if (rd_random) begin
      #1;
      rd_ready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic setRdReady(input logic v);
    @(posedge clk_rd);
    #1;
    rd_ready = v;
  endtask

  // Called at posedge clk_wr + 1; returns at posedge + 1 of the accepting edge with wr_valid still high.
  task automatic applyStimulus(input logic [WIDTH-1:0] word, input bit track, output int waited);
    logic rdy;
    if (track) exp_q.push_back(word);
    wr_data  = word;
    wr_valid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk_wr);
      rdy = wr_ready;
      @(posedge clk_wr);
      if (rdy) break;
      waited++;
      if (waited > 2000) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: got no accept for 0x%08h, required accept within 2000 cycles", word);
        break;
      end
    end
    #1;
  endtask

  task automatic waitWrIdle(input string name);
    int n = 0;
    while (!(wr_ready === 1'b1 && busy === 1'b0) && n < 5000) begin
      @(negedge clk_wr);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("[TB] FAIL %s_idle_timeout: got wr_ready=%b busy=%b, required 1/0", name, wr_ready, busy);
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk_rd);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("[TB] FAIL %s_drain_timeout: got %0d words pending, required 0", name, exp_q.size());
    end
    waitWrIdle(name);
    @(posedge clk_wr);
    #1;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w, w2, base, dbase, n;
    rst_wr = 1'b0; rst_rd = 1'b0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    #1;
    rst_wr = 1'b1; rst_rd = 1'b1;
    repeat (5) @(posedge clk_rd);
    #2;
    rst_wr = 1'b0; rst_rd = 1'b0;
    repeat (3) @(posedge clk_wr);
    #1;
    checkOutput("reset_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset_rd_data", rd_data, 32'd0);

    // single word, consumer always ready: one-cycle rd_valid pulse
    setRdReady(1'b1);
    @(posedge clk_wr); #1;
    base = rd_valid_cycles; dbase = delivered;
    applyStimulus(32'hDEADBEEF, 1'b1, w);
    wr_valid = 1'b0;
    waitDrain("deadbeef");
    checkOutput("deadbeef_valid_cycles", 32'(rd_valid_cycles - base), 32'd1);
    checkOutput("deadbeef_deliveries", 32'(delivered - dbase), 32'd1);
    checkOutput("deadbeef_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("deadbeef_busy", 32'(busy), 32'd0);

    // consumer stall for 50 read cycles
    setRdReady(1'b0);
    @(posedge clk_wr); #1;
    applyStimulus(32'h12345678, 1'b1, w);
    wr_valid = 1'b0;
    n = 0;
    while (rd_valid !== 1'b1 && n < 1000) begin @(negedge clk_rd); n++; end
    checkOutput("stall_rd_valid_seen", 32'(rd_valid), 32'd1);
    dbase = delivered;
    repeat (50) begin
      @(negedge clk_rd);
      checkOutput("stall_rd_valid", 32'(rd_valid), 32'd1);
      checkOutput("stall_rd_data", rd_data, 32'h12345678);
`ifdef HANDSHAKE_BUS_SYNC_SKID_EN
      checkOutput("stall_wr_ready", 32'(wr_ready), 32'd1);
`else
      checkOutput("stall_wr_ready", 32'(wr_ready), 32'd0);
`endif
    end
    checkOutput("stall_no_delivery", 32'(delivered - dbase), 32'd0);
    setRdReady(1'b1);
    waitDrain("stall");
    repeat (10) @(negedge clk_rd);
    checkOutput("stall_deliveries", 32'(delivered - dbase), 32'd1);
    @(posedge clk_wr); #1;

    // incrementing bursts at 1:1, 3:1 and 1:3 clock ratios
    for (int r = 0; r < 3; r++) begin
      wr_half = (r == 2) ? 15.0 : 5.0;
      rd_half = (r == 1) ? 15.0 : 5.0;
      repeat (4) @(posedge clk_rd);
      @(posedge clk_wr); #1;
      dbase = delivered;
      for (int i = 0; i < 256; i++) applyStimulus(32'(i), 1'b1, w);
      wr_valid = 1'b0;
      waitDrain("burst");
      checkOutput("burst_deliveries", 32'(delivered - dbase), 32'd256);
    end

    wr_half = 5.0;
    rd_half = 13.5;
    repeat (4) @(posedge clk_rd);
    @(posedge clk_wr); #1;

`ifdef HANDSHAKE_BUS_SYNC_SKID_EN
    // back-to-back pair: second word parks in the skid register before the first ack
    applyStimulus(32'hA1, 1'b1, w);
    applyStimulus(32'hA2, 1'b1, w2);
    wr_valid = 1'b0;
    checkOutput("skid_second_wait", 32'(w2), 32'd0);
    checkOutput("skid_full_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("skid_full_busy", 32'(busy), 32'd1);
    waitDrain("skid");
    checkOutput("skid_busy_after", 32'(busy), 32'd0);
`endif

    // both resets during WAIT_ACK; the in-flight word must vanish
    setRdReady(1'b0);
    @(posedge clk_wr); #1;
    applyStimulus(32'h99, 1'b0, w);
    wr_valid = 1'b0;
    repeat (4) @(posedge clk_wr);
    #1;
    checkOutput("midreset_busy_before", 32'(busy), 32'd1);
    rst_wr = 1'b1; rst_rd = 1'b1;
    #1;
    checkOutput("midreset_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("midreset_rd_data", rd_data, 32'd0);
    repeat (4) @(posedge clk_rd);
    #2;
    rst_wr = 1'b0; rst_rd = 1'b0;
    setRdReady(1'b1);
    @(posedge clk_wr); #1;
    dbase = delivered;
    applyStimulus(32'h55, 1'b1, w);
    wr_valid = 1'b0;
    waitDrain("midreset");
    repeat (30) @(negedge clk_rd);
    checkOutput("midreset_deliveries", 32'(delivered - dbase), 32'd1);
    @(posedge clk_wr); #1;

    // random data, random gaps, random backpressure, random clock ratio
    wr_half = realtime'($urandom_range(3, 20));
    rd_half = realtime'($urandom_range(3, 20));
    rd_random = 1'b1;
    @(posedge clk_wr); #1;
    dbase = delivered;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        wr_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk_wr);
        #1;
      end
      applyStimulus($urandom, 1'b1, w);
    end
    wr_valid = 1'b0;
    waitDrain("random");
    rd_random = 1'b0;
    checkOutput("random_deliveries", 32'(delivered - dbase), 32'd60);

    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/handshake_bus_sync.md
Name: handshake_bus_sync

Overview:
- Moves one WIDTH-bit word at a time from the clk_wr domain to the clk_rd domain.
- Uses a toggle request/acknowledge handshake. The held write-side word is the only multi-bit signal that crosses domains, and it is stable whenever the read side samples it.
- The read side presents the word on a valid/ready interface. The acknowledge returns only after the consumer accepts, so read-side backpressure reaches the writer.
- Sits between register/stream producers in the write domain and consumers in the read domain of the interface bridge.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- SYNC_STAGES, 2, flops per synchronizer chain in each direction (>=2).

Ports:
- clk_wr  input  1  write-domain clock.
- rst_wr  input  1  write-domain reset, asynchronous, active-high.
- clk_rd  input  1  read-domain clock.
- rst_rd  input  1  read-domain reset, asynchronous, active-high.
- wr_data  input  WIDTH  word to transfer.
- wr_valid  input  1  word offered (clk_wr).
- wr_ready  output  1  word accepted when wr_valid&&wr_ready (clk_wr).
- busy  output  1  transfer in flight (clk_wr).
- rd_data  output  WIDTH  delivered word (clk_rd).
- rd_valid  output  1  rd_data valid (clk_rd).
- rd_ready  input  1  consumer accepts when rd_valid&&rd_ready (clk_rd).

Behaviour:
- Interface: the only clock and reset of the write domain are clk_wr and rst_wr; rst_wr is asynchronous, active-high. rst_rd is also asynchronous, active-high.
- Reset values: wr_ready=1, busy=0, rd_valid=0, rd_data=0; all toggles, synchronizer flops and hold registers =0.
- Write FSM, state IDLE: wr_ready=1. On accept: hold_r<=wr_data, req_tgl<=~req_tgl, go to WAIT_ACK.
- Write FSM, state WAIT_ACK: wr_ready=0, busy=1.
  - ack_tgl is synchronized through SYNC_STAGES flops, then edge-detected against a registered copy.
  - Edge detected -> go to IDLE; wr_ready=1 from that cycle.
- hold_r changes only on accept in IDLE. It is stable from the req toggle until the ack edge.
- Read side:
  - req_tgl is synchronized through SYNC_STAGES flops, then edge-detected.
  - On the edge: rd_data<=hold_r, rd_valid<=1.
  - While rd_valid=1 and rd_ready=0: rd_data and rd_valid hold.
  - On rd_valid&&rd_ready: rd_valid<=0, ack_tgl<=~ack_tgl.
- Latency with SYNC_STAGES=2:
  - rd_valid rises on the 3rd clk_rd edge after req_tgl changes.
  - wr_ready rises on the 3rd clk_wr edge after ack_tgl changes.
  - Throughput is at most one word per round trip.
- rd_ready held high before rd_valid: the word is consumed on the first rd_valid cycle, and rd_valid is a one-cycle pulse.
- wr_valid while wr_ready=0: ignored. The producer must hold the word; no loss and no duplicate.
- Exactly one rd_valid handshake per write accept. Never duplicated, never dropped.
- Toggle wrap: toggles are 1 bit. Every transition is an event, so there is no counter overflow.
- Reset:
  - rst_wr and rst_rd are asserted together by the system.
  - Either reset alone mid-transfer is unsupported; the bench does not check it.
  - After both resets release, the first accept transfers normally.
- Frequency: the clk_wr/clk_rd ratio is unrestricted.

Optional Feature:
- Macro: HANDSHAKE_BUS_SYNC_SKID_EN.
- Defined:
  - Adds a one-deep write-side skid register skid_r plus a skid_full flag.
  - In WAIT_ACK, wr_ready = ~skid_full. An accept loads skid_r and sets skid_full.
  - On the ack edge with skid_full=1: hold_r<=skid_r, skid_full<=0, req_tgl toggles, state stays WAIT_ACK.
  - busy = (state==WAIT_ACK) || skid_full.
- Not defined: no skid logic; wr_ready=0 throughout WAIT_ACK.

Test Plan:
- Reset both domains, then hold -> wr_ready=1, busy=0, rd_valid=0, rd_data=0.
- clk_wr 100MHz, clk_rd 37MHz, write 0xDEADBEEF with rd_ready=1 -> one rd_valid pulse, rd_data=0xDEADBEEF; wr_ready returns high; busy low again.
- rd_ready=0 for 50 clk_rd cycles after rd_valid -> rd_valid and rd_data=0x12345678 stable; wr_ready stays 0; after rd_ready=1, exactly one accept, then wr_ready rises.
- Burst of 256 incrementing words 0..255, wr_valid continuously high, clk ratios 1:1, 3:1, 1:3 -> read side receives 0..255 in order, no gaps, no duplicates.
- With HANDSHAKE_BUS_SYNC_SKID_EN, words 0xA1 then 0xA2 back-to-back -> both accepted before the first ack (wr_ready low only once skid is full); read order 0xA1, 0xA2; busy low after the second ack.
- Assert both resets mid-transfer (during WAIT_ACK) -> outputs return to reset values; next word 0x55 is delivered exactly once.
